// File: rtl/reg_select_pkg.sv
// Shared types and default widths for the register-select encoder slice.
package reg_select_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int DEF_NUM_LINES = 2;
  localparam int DEF_ID_W      = $clog2(DEF_NUM_LINES);

endpackage

// File: rtl/reg_select_encoder_prio_enc.sv
// Lowest-set-bit priority encoder, purely combinational.
// Zero latency; no flow control.
module prio_enc
  import reg_select_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int ID_W      = DEF_ID_W
) (
  input  logic [NUM_LINES-1:0] vec,
  output logic [ID_W-1:0]      idx,
  output logic                 any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Walk from the top down so the lowest set bit wins.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (vec[i]) idx = ID_W'(i);
    end
  end

endmodule

// File: rtl/reg_select_encoder.sv
// Serializes a multi-hot select vector into one {enable, reg_id} per cycle, lowest index first.
// Latency: first id the cycle after acceptance. Backpressure: out_ready low holds the id; req_ready low while draining.
// Optional REG_SELECT_ONEHOT_CHECK_EN: multi-hot vectors are dropped and flag a sticky err.
module reg_select_encoder
  import reg_select_pkg::*;
#(
  parameter int NUM_LINES = DEF_NUM_LINES,
  parameter int ID_W      = $clog2(NUM_LINES)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LINES-1:0] req,
  input  logic                 req_valid,
  output logic                 req_ready,
  output logic                 enable,
  output logic [ID_W-1:0]      reg_id,
  input  logic                 out_ready,
  output logic                 done,
  output logic                 err
);

  state_t                state, state_nxt;
  logic [NUM_LINES-1:0]  pending, pending_nxt;
  logic [NUM_LINES-1:0]  clr_mask;
  logic [NUM_LINES-1:0]  remaining;
  logic [ID_W-1:0]       low_idx;
  logic                  low_any;
  logic                  multi;

  prio_enc #(
    .NUM_LINES(NUM_LINES),
    .ID_W     (ID_W)
  ) u_enc (
    .vec(pending),
    .idx(low_idx),
    .any(low_any)
  );

  assign clr_mask  = NUM_LINES'(1) << low_idx;
  assign remaining = pending & ~clr_mask;

`ifdef REG_SELECT_ONEHOT_CHECK_EN
  logic err_q, err_nxt;

  function automatic logic popcount_gt1(input logic [NUM_LINES-1:0] v);
    int cnt = 0;
    for (int i = 0; i < NUM_LINES; i++) cnt += int'(v[i]);
    return cnt > 1;
  endfunction

  assign multi = popcount_gt1(req);
  assign err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_nxt;
  end

  always_comb begin
    err_nxt = err_q;
    if (state == IDLE && req_valid && multi) err_nxt = 1'b1;
  end
`else
  assign multi = 1'b0;
  assign err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    req_ready   = 1'b0;
    enable      = 1'b0;
    reg_id      = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        // Zero vectors (and multi-hot ones when checking) are consumed without effect.
        if (req_valid && req != '0 && !multi) begin
          pending_nxt = req;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        enable = low_any;
        reg_id = low_idx;
        if (out_ready) begin
          pending_nxt = remaining;
          if (remaining == '0) begin
            // A reset in the same cycle wins, so no completion is reported.
            done      = ~rst;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_select_encoder.sv
// Scoreboard bench for reg_select_encoder with a 4-line instance, directed then random stimulus.
module tb_reg_select_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic         enable;
  logic [W-1:0] reg_id;
  logic         out_ready = 1'b0;
  logic         done;
  logic         err;

  reg_select_encoder #(.NUM_LINES(N), .ID_W(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .enable   (enable),
    .reg_id   (reg_id),
    .out_ready(out_ready),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    bit last;
  } item_t;

  item_t q[$];
  int    passed = 0;
  int    total  = 0;
  bit    exp_err = 1'b0;
  bit    stop = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // One bus cycle. Expected ids are computed from the vector's set bits and
  // committed to the scoreboard once the accepting edge has passed.
  task automatic cycle(input bit v, input logic [N-1:0] r, input bit o, input bit rs);
    item_t stage[$];
    bit    mh = 1'b0;
    bit    set_err = 1'b0;
    req_valid = v;
    req       = r;
    out_ready = o;
    rst       = rs;
`ifdef REG_SELECT_ONEHOT_CHECK_EN
    mh = ($countones(r) > 1);
`endif
    if (!rs && v && q.size() == 0 && r != '0) begin
      if (mh) set_err = 1'b1;
      else begin
        int seen = 0;
        int tot  = $countones(r);
        for (int i = 0; i < N; i++) begin
          if (r[i]) begin
            item_t it;
            seen++;
            it.id   = i;
            it.last = (seen == tot);
            stage.push_back(it);
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      exp_err = 1'b0;
    end else begin
      foreach (stage[i]) q.push_back(stage[i]);
      if (set_err) exp_err = 1'b1;
    end
  endtask

  // Monitor: compares DUT outputs against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !stop) begin
        chk("req_ready", int'(req_ready), (q.size() == 0) ? 1 : 0);
        chk("err", int'(err), int'(exp_err));
        if (q.size() != 0) begin
          chk("enable", int'(enable), 1);
          chk("reg_id", int'(reg_id), q[0].id);
          chk("done", int'(done), (out_ready && q[0].last) ? 1 : 0);
          if (out_ready) void'(q.pop_front());
        end else begin
          chk("enable_idle", int'(enable), 0);
          chk("reg_id_idle", int'(reg_id), 0);
          chk("done_idle", int'(done), 0);
        end
      end
    end
  end

  initial begin
    cycle(0, 4'b0000, 0, 1);
    cycle(0, 4'b0000, 0, 1);
    cycle(0, 4'b0000, 1, 0);

    // single line
    cycle(1, 4'b0010, 1, 0);
    repeat (2) cycle(0, 4'b0000, 1, 0);

    // serialization
    cycle(1, 4'b1011, 1, 0);
    repeat (4) cycle(0, 4'b0000, 1, 0);

    // backpressure, with a vector offered mid-drain
    cycle(1, 4'b0110, 0, 0);
    cycle(0, 4'b0000, 0, 0);
    cycle(1, 4'b1111, 0, 0);
    cycle(0, 4'b0000, 0, 0);
    repeat (3) cycle(0, 4'b0000, 1, 0);

    // zero vector
    cycle(1, 4'b0000, 1, 0);
    repeat (2) cycle(0, 4'b0000, 1, 0);

    // reset in the second drain cycle
    cycle(1, 4'b1111, 1, 0);
    cycle(0, 4'b0000, 1, 0);
    cycle(0, 4'b0000, 0, 1);
    repeat (2) cycle(0, 4'b0000, 1, 0);

    // multi-hot then one-hot (err behaviour depends on build)
    cycle(1, 4'b0011, 1, 0);
    repeat (3) cycle(0, 4'b0000, 1, 0);
    cycle(1, 4'b0001, 1, 0);
    repeat (2) cycle(0, 4'b0000, 1, 0);

    for (int n = 0; n < 3000; n++) begin
      bit          rs = ($urandom_range(0, 99) == 0);
      bit          v  = 1'($urandom_range(0, 1));
      logic [N-1:0] r = N'($urandom);
      bit          o  = ($urandom_range(0, 3) != 0);
      if (rs) o = 1'b0;
      cycle(v, r, o, rs);
    end

    for (int i = 0; i < 40 && q.size() != 0; i++) cycle(0, 4'b0000, 1, 0);
    chk("drain_empty", q.size(), 0);

    stop = 1'b1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
